gl_regsta: RTL and testbench

- General-purpose storage primitive pair in one block.
- (a) Load-enabled data register, used for SFRs, DACV, offset and LSB registers.
- (b) Set/clear status register with a per-bit interrupt output, used for the comparator-change status (CMPSTA) and its interrupt.
- Instantiated throughout the DAC/ADC mux logic. The two halves share only clock and reset.

---
 rtl/gl_regsta.sv | 60 ++++++
 tb/tb_gl_regsta.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gl_regsta.sv
// ---------------------------------------------------------------------------
// gl_regsta: general-purpose storage pair sharing only clock and reset.
//   (a) load-enabled data register (SFRs, DACV, offset and LSB registers)
//   (b) set/clear status register with per-bit level interrupt (CMPSTA)
//
// Ports:
//   clk       rising-edge clock
//   srst      synchronous active-high reset, overrides every other input
//   reg_we    data register load enable
//   reg_wdat  data register write data (REG_W bits)
//   reg_q     data register contents (REG_W bits)
//   sta_mask  global interrupt mask, 1 forces sta_irq to 0
//   sta_set   per-bit set requests (STA_W bits)
//   sta_clr   per-bit write-1-to-clear requests (STA_W bits)
//   sta_q     status register contents (STA_W bits)
//   sta_irq   per-bit interrupt request (STA_W bits)
//   irq_any   OR of sta_irq
// ---------------------------------------------------------------------------
module gl_regsta #(
    parameter int REG_W = 8,
    parameter int STA_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             reg_we,
    input  logic [REG_W-1:0] reg_wdat,
    output logic [REG_W-1:0] reg_q,
    input  logic             sta_mask,
    input  logic [STA_W-1:0] sta_set,
    input  logic [STA_W-1:0] sta_clr,
    output logic [STA_W-1:0] sta_q,
    output logic [STA_W-1:0] sta_irq,
    output logic             irq_any
);

    // Data register: plain load-enabled flop bank.
    always_ff @(posedge clk) begin
        if (srst) begin
            reg_q <= '0;
        end else if (reg_we) begin
            reg_q <= reg_wdat;
        end
    end

    // Status register: set wins over a colliding clear, so an event that
    // arrives in the same cycle as software's acknowledge is never lost.
    always_ff @(posedge clk) begin
        if (srst) begin
            sta_q <= '0;
        end else begin
            sta_q <= sta_set | (sta_q & ~sta_clr);
        end
    end

    // The mask only gates the request; the latched status is untouched, so
    // anything that arrived while masked shows up once the mask drops.
    assign sta_irq = sta_mask ? '0 : sta_q;
    assign irq_any = |sta_irq;

endmodule

// File: tb/tb_gl_regsta.sv
// ---------------------------------------------------------------------------
// tb_gl_regsta: self-checking bench for gl_regsta (REG_W = STA_W = 8).
// A behavioural model tracks the data word and the status bits; every
// clock edge pushes the model's expected state into exp_q, and each check
// pops it and compares against the design outputs.
// ---------------------------------------------------------------------------
module tb_gl_regsta;

    localparam int W = 8;

    logic         clk;
    logic         srst;
    logic         reg_we;
    logic [W-1:0] reg_wdat;
    logic [W-1:0] reg_q;
    logic         sta_mask;
    logic [W-1:0] sta_set;
    logic [W-1:0] sta_clr;
    logic [W-1:0] sta_q;
    logic [W-1:0] sta_irq;
    logic         irq_any;

    int passed = 0;
    int total  = 0;

    // Model state.
    logic [W-1:0] m_reg;
    logic [W-1:0] m_sta;

    // Scoreboard: each entry is {expected reg_q, expected sta_q}.
    logic [2*W-1:0] exp_q[$];

    gl_regsta #(.REG_W(W), .STA_W(W)) dut (
        .clk      (clk),
        .srst     (srst),
        .reg_we   (reg_we),
        .reg_wdat (reg_wdat),
        .reg_q    (reg_q),
        .sta_mask (sta_mask),
        .sta_set  (sta_set),
        .sta_clr  (sta_clr),
        .sta_q    (sta_q),
        .sta_irq  (sta_irq),
        .irq_any  (irq_any)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic we, input logic [W-1:0] wdat,
                         input logic mask, input logic [W-1:0] set, input logic [W-1:0] clr);
        srst     = rst;
        reg_we   = we;
        reg_wdat = wdat;
        sta_mask = mask;
        sta_set  = set;
        sta_clr  = clr;
    endtask

    // Advance one clock; the model applies the rules to the inputs the
    // design sampled at this edge, then the expected state is queued.
    task automatic tick();
        @(posedge clk);
        if (srst) begin
            m_reg = '0;
            m_sta = '0;
        end else begin
            if (reg_we) m_reg = reg_wdat;
            for (int i = 0; i < W; i++) begin
                if (sta_set[i])      m_sta[i] = 1'b1;
                else if (sta_clr[i]) m_sta[i] = 1'b0;
            end
        end
        exp_q.push_back({m_reg, m_sta});
        #1;
    endtask

    task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Check outputs against the model state given the current mask.
    task automatic check_state(input string tag, input logic [W-1:0] e_reg, input logic [W-1:0] e_sta);
        logic [W-1:0] e_irq;
        e_irq = sta_mask ? '0 : e_sta;
        cmp({tag, ".reg_q"},   reg_q,   e_reg);
        cmp({tag, ".sta_q"},   sta_q,   e_sta);
        cmp({tag, ".sta_irq"}, sta_irq, e_irq);
        cmp({tag, ".irq_any"}, {{(W-1){1'b0}}, irq_any}, {{(W-1){1'b0}}, |e_irq});
    endtask

    // Pop the scoreboard entry queued by the last tick and check it.
    task automatic check(input string tag);
        logic [2*W-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_state(tag, e[2*W-1:W], e[W-1:0]);
        end
    endtask

    // Check against independent hand-derived constants.
    task automatic expect_const(input string tag, input logic [W-1:0] e_reg, input logic [W-1:0] e_sta);
        check_state(tag, e_reg, e_sta);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        m_reg = '0;
        m_sta = '0;
        drive(1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h00);
        tick(); check("rst_we");
        expect_const("rst_const", 8'h00, 8'h00);

        // Write and hold
        drive(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 8'h00);
        tick(); check("write");
        expect_const("write_const", 8'h3C, 8'h00);
        drive(1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 8'h00);
        tick(); check("hold");
        expect_const("hold_const", 8'h3C, 8'h00);

        // Set/clear basics
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 8'h00);
        tick(); check("set05");
        expect_const("set05_const", 8'h3C, 8'h05);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01);
        tick(); check("clr01");
        expect_const("clr01_const", 8'h3C, 8'h04);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h04);
        tick(); check("clr04");
        expect_const("clr04_const", 8'h3C, 8'h00);
        // Clear of an already-clear bit
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h08);
        tick(); check("clr_zero");

        // Set-over-clear collision
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 8'h00);
        tick(); check("pre_coll");
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 8'hFF);
        tick(); check("collision");
        expect_const("collision_const", 8'h3C, 8'h02);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h02);
        tick(); check("post_coll");

        // Repeated set coalesces
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 8'h00);
            tick(); check("rep_set");
            expect_const("rep_set_const", 8'h3C, 8'h80);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h80);
        tick(); check("rep_clr");
        expect_const("rep_clr_const", 8'h3C, 8'h00);

        // Mask: status latches, request suppressed, then released same cycle
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00);
        tick(); check("masked");
        cmp("masked.sta_irq_const", sta_irq, 8'h00);
        cmp("masked.sta_q_const",   sta_q,   8'h10);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        #1;
        expect_const("unmask_comb", 8'h3C, 8'h10);
        cmp("unmask.sta_irq_const", sta_irq, 8'h10);
        tick(); check("unmask_hold");

        // Reset mid-operation
        drive(1'b0, 1'b1, 8'h55, 1'b0, 8'hFF, 8'h00);
        tick(); check("pre_rst");
        expect_const("pre_rst_const", 8'h55, 8'hFF);
        drive(1'b1, 1'b1, 8'hAA, 1'b0, 8'hFF, 8'h00);
        tick(); check("mid_rst");
        expect_const("mid_rst_const", 8'h00, 8'h00);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1), W'($urandom),
                  ($urandom_range(0, 3) == 0),
                  W'($urandom) & W'($urandom) & W'($urandom),
                  W'($urandom) & W'($urandom));
            tick(); check("rand");
        end

        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
